// File: rtl/usram_triport_ctrl.sv
// ----------------------------------------------------------------------------
// usram_triport_ctrl
//   Single-clock micro-SRAM with one write port (W) and two independent read
//   ports (A, B). Read latency is selectable (0/1/2 cycles). Each read port
//   has a valid flag and a same-cycle read/write collision flag. A clear
//   state machine zero-fills the array after reset and on request.
//
// Ports
//   clk, rst                   single clock, asynchronous active-high reset
//   init_req / init_busy       clear request (honoured in READY) / clearing
//   wen, waddr, wdata          write port
//   aren, araddr -> ardata, arvalid, a_collision   read port A
//   bren, braddr -> brdata, brvalid, b_collision   read port B
//   access_err                 an access was dropped during a clear
// ----------------------------------------------------------------------------
package USRAM_package;
   typedef enum logic [2:0] {RAM64x18, RAM128x9, RAM256x4, RAM512x2, RAM1Kx1} mode_type;

   function automatic int data_width_fn(mode_type m);
      case (m)
         RAM64x18: return 18;
         RAM128x9: return 9;
         RAM256x4: return 4;
         RAM512x2: return 2;
         default:  return 1;
      endcase
   endfunction

   function automatic int addr_depth_fn(mode_type m);
      case (m)
         RAM64x18: return 64;
         RAM128x9: return 128;
         RAM256x4: return 256;
         RAM512x2: return 512;
         default:  return 1024;
      endcase
   endfunction
endpackage

module usram_triport_ctrl
   import USRAM_package::*;
#(
   parameter mode_type MODE          = RAM64x18,
   parameter int       DATA_WIDTH    = data_width_fn(MODE),
   parameter int       ADDR_DEPTH    = addr_depth_fn(MODE),
   parameter int       ADDR_WIDTH    = $clog2(ADDR_DEPTH),
   parameter int       READ_PIPE     = 1,
   parameter bit       INIT_ON_RESET = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  init_req,
   output logic                  init_busy,
   input  logic                  wen,
   input  logic [ADDR_WIDTH-1:0] waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic                  aren,
   input  logic [ADDR_WIDTH-1:0] araddr,
   output logic [DATA_WIDTH-1:0] ardata,
   output logic                  arvalid,
   output logic                  a_collision,
   input  logic                  bren,
   input  logic [ADDR_WIDTH-1:0] braddr,
   output logic [DATA_WIDTH-1:0] brdata,
   output logic                  brvalid,
   output logic                  b_collision,
   output logic                  access_err
);

   typedef enum logic {ST_CLEAR, ST_READY} state_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
   logic                  clearing;

   // ---------------- clear state machine ----------------
   always_comb begin
      // NOTE: every always_comb output gets a default first so no latch is inferred.
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_CLEAR: begin
            cnt_d = cnt_q + ADDR_WIDTH'(1);
            if (cnt_q == ADDR_WIDTH'(ADDR_DEPTH - 1)) begin
               state_d = ST_READY;
               cnt_d   = '0;
            end
         end
         default: begin
            if (init_req) begin
               state_d = ST_CLEAR;
               cnt_d   = '0;
            end
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= INIT_ON_RESET ? ST_CLEAR : ST_READY;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   assign clearing  = (state_q == ST_CLEAR);
   assign init_busy = clearing;

   // ---------------- storage array ----------------
   logic [DATA_WIDTH-1:0] mem [ADDR_DEPTH];
   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_waddr;
   logic [DATA_WIDTH-1:0] mem_wdata;

   // The clear engine owns the write port while clearing; user writes are dropped.
   always_comb begin
      mem_we    = clearing | wen;
      mem_waddr = clearing ? cnt_q : waddr;
      mem_wdata = clearing ? '0 : wdata;
   end

   // NOTE: the array has no reset; it is zeroed by the clear state machine instead.
   always_ff @(posedge clk) begin
      if (mem_we) mem[mem_waddr] <= mem_wdata;
   end

   // ---------------- read ports (index 0 = A, 1 = B) ----------------
   logic [1:0]            rd_en, rd_issue, rd_col;
   logic [ADDR_WIDTH-1:0] rd_addr  [2];
   logic [DATA_WIDTH-1:0] rd_mem   [2];
   logic [DATA_WIDTH-1:0] out_data [2];
   logic [1:0]            out_valid, out_col;

   // First data stage; with READ_PIPE = 0 it only holds the last returned word.
   logic [DATA_WIDTH-1:0] s1_data_q [2];
   logic [DATA_WIDTH-1:0] s1_data_d [2];

   always_comb begin
      rd_en      = {bren, aren};
      rd_addr[0] = araddr;
      rd_addr[1] = braddr;
      for (int p = 0; p < 2; p++) begin
         rd_issue[p]  = ~clearing & rd_en[p];
         // Same-cycle write to the read address; the read sees pre-write data.
         rd_col[p]    = rd_issue[p] & wen & (waddr == rd_addr[p]);
         rd_mem[p]    = mem[rd_addr[p]];
         s1_data_d[p] = rd_issue[p] ? rd_mem[p] : s1_data_q[p];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_data_q[0] <= '0;
         s1_data_q[1] <= '0;
      end else begin
         s1_data_q[0] <= s1_data_d[0];
         s1_data_q[1] <= s1_data_d[1];
      end
   end

   if (READ_PIPE == 0) begin : g_pipe0
      always_comb begin
         for (int p = 0; p < 2; p++) begin
            out_data[p] = rd_issue[p] ? rd_mem[p] : s1_data_q[p];
         end
         out_valid = rd_issue;
         out_col   = rd_col;
      end
   end else begin : g_pipe_sync
      logic [1:0] s1_valid_q, s1_valid_d, s1_col_q, s1_col_d;

      always_comb begin
         s1_valid_d = rd_issue;
         s1_col_d   = rd_col;
      end

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            s1_valid_q <= '0;
            s1_col_q   <= '0;
         end else begin
            s1_valid_q <= s1_valid_d;
            s1_col_q   <= s1_col_d;
         end
      end

      if (READ_PIPE == 1) begin : g_pipe1
         always_comb begin
            out_data  = s1_data_q;
            out_valid = s1_valid_q;
            out_col   = s1_col_q;
         end
      end else begin : g_pipe2
         logic [DATA_WIDTH-1:0] s2_data_q [2];
         logic [DATA_WIDTH-1:0] s2_data_d [2];
         logic [1:0]            s2_valid_q, s2_valid_d, s2_col_q, s2_col_d;

         always_comb begin
            for (int p = 0; p < 2; p++) begin
               s2_data_d[p] = s1_valid_q[p] ? s1_data_q[p] : s2_data_q[p];
            end
            s2_valid_d = s1_valid_q;
            s2_col_d   = s1_col_q;
         end

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               s2_data_q[0] <= '0;
               s2_data_q[1] <= '0;
               s2_valid_q   <= '0;
               s2_col_q     <= '0;
            end else begin
               s2_data_q[0] <= s2_data_d[0];
               s2_data_q[1] <= s2_data_d[1];
               s2_valid_q   <= s2_valid_d;
               s2_col_q     <= s2_col_d;
            end
         end

         always_comb begin
            out_data  = s2_data_q;
            out_valid = s2_valid_q;
            out_col   = s2_col_q;
         end
      end
   end

   assign ardata      = out_data[0];
   assign arvalid     = out_valid[0];
   assign a_collision = out_col[0];
   assign brdata      = out_data[1];
   assign brvalid     = out_valid[1];
   assign b_collision = out_col[1];

   // ---------------- dropped-access flag ----------------
   logic wr_drop, rd_drop, err_q, err_d;

   // With a combinational read path a dropped read is flagged in the same
   // cycle; anything involving a dropped write is flagged one cycle later.
   always_comb begin
      wr_drop = clearing & wen;
      rd_drop = clearing & (aren | bren);
      err_d   = wr_drop | (rd_drop & (READ_PIPE != 0));
      access_err = err_q | ((READ_PIPE == 0) & rd_drop & ~wr_drop);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) err_q <= 1'b0;
      else     err_q <= err_d;
   end

endmodule

// File: tb/tb_usram_triport_ctrl.sv
// ----------------------------------------------------------------------------
// tb_usram_triport_ctrl
//   Directed bench for usram_triport_ctrl. Three instances share clk/rst:
//   u1 (RAM64x18, 1-cycle read), u2 (RAM64x18, 2-cycle read, same inputs as
//   u1) and u0 (RAM1Kx1, combinational read, own inputs).
// ----------------------------------------------------------------------------
module tb_usram_triport_ctrl;
   import USRAM_package::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // shared inputs for u1 / u2
   logic        init_req, wen, aren, bren;
   logic [5:0]  waddr, araddr, braddr;
   logic [17:0] wdata;

   logic [17:0] a1_ardata, a1_brdata, a2_ardata, a2_brdata;
   logic        a1_busy, a1_arvalid, a1_brvalid, a1_acol, a1_bcol, a1_err;
   logic        a2_busy, a2_arvalid, a2_brvalid, a2_acol, a2_bcol, a2_err;

   // RAM1Kx1 inputs/outputs
   logic        k_init_req, k_wen, k_aren, k_bren;
   logic [9:0]  k_waddr, k_araddr, k_braddr;
   logic [0:0]  k_wdata, k_ardata, k_brdata;
   logic        k_busy, k_arvalid, k_brvalid, k_acol, k_bcol, k_err;

   usram_triport_ctrl #(.MODE(RAM64x18), .READ_PIPE(1), .INIT_ON_RESET(1'b1)) u1 (
      .clk(clk), .rst(rst), .init_req(init_req), .init_busy(a1_busy),
      .wen(wen), .waddr(waddr), .wdata(wdata),
      .aren(aren), .araddr(araddr), .ardata(a1_ardata), .arvalid(a1_arvalid), .a_collision(a1_acol),
      .bren(bren), .braddr(braddr), .brdata(a1_brdata), .brvalid(a1_brvalid), .b_collision(a1_bcol),
      .access_err(a1_err));

   usram_triport_ctrl #(.MODE(RAM64x18), .READ_PIPE(2), .INIT_ON_RESET(1'b1)) u2 (
      .clk(clk), .rst(rst), .init_req(init_req), .init_busy(a2_busy),
      .wen(wen), .waddr(waddr), .wdata(wdata),
      .aren(aren), .araddr(araddr), .ardata(a2_ardata), .arvalid(a2_arvalid), .a_collision(a2_acol),
      .bren(bren), .braddr(braddr), .brdata(a2_brdata), .brvalid(a2_brvalid), .b_collision(a2_bcol),
      .access_err(a2_err));

   usram_triport_ctrl #(.MODE(RAM1Kx1), .READ_PIPE(0), .INIT_ON_RESET(1'b1)) u0 (
      .clk(clk), .rst(rst), .init_req(k_init_req), .init_busy(k_busy),
      .wen(k_wen), .waddr(k_waddr), .wdata(k_wdata),
      .aren(k_aren), .araddr(k_araddr), .ardata(k_ardata), .arvalid(k_arvalid), .a_collision(k_acol),
      .bren(k_bren), .braddr(k_braddr), .brdata(k_brdata), .brvalid(k_brvalid), .b_collision(k_bcol),
      .access_err(k_err));

   int n_cmp  = 0;
   int n_fail = 0;
   int busy_samples;
   int guard;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Step and count the cycle if u1 is still clearing afterwards.
   task automatic step_cnt();
      step();
      if (a1_busy) busy_samples++;
   endtask

   typedef struct {
      logic        wen;
      logic [5:0]  waddr;
      logic [17:0] wdata;
      logic        aren;
      logic [5:0]  araddr;
      logic        bren;
      logic [5:0]  braddr;
      logic [17:0] ea;
      logic        eav, eac;
      logic [17:0] eb;
      logic        ebv, ebc;
   } vec_t;

   function automatic vec_t mk(logic w, logic [5:0] wa, logic [17:0] wd,
                               logic ae, logic [5:0] aa, logic be, logic [5:0] ba,
                               logic [17:0] ea, logic eav, logic eac,
                               logic [17:0] eb, logic ebv, logic ebc);
      vec_t v;
      v.wen = w;  v.waddr = wa; v.wdata = wd;
      v.aren = ae; v.araddr = aa; v.bren = be; v.braddr = ba;
      v.ea = ea; v.eav = eav; v.eac = eac;
      v.eb = eb; v.ebv = ebv; v.ebc = ebc;
      return v;
   endfunction

   vec_t vecs [10];
   vec_t prev;

   initial begin
      // Expected u1 (1-cycle) outputs after each vector's clock edge.
      vecs[0] = mk(1, 5,  18'h2A5A5, 0, 0,  0, 0,   18'h00000, 0, 0, 18'h00000, 0, 0);
      vecs[1] = mk(0, 0,  18'h0,     1, 5,  0, 0,   18'h2A5A5, 1, 0, 18'h00000, 0, 0);
      vecs[2] = mk(1, 9,  18'h00011, 0, 0,  0, 0,   18'h2A5A5, 0, 0, 18'h00000, 0, 0);
      vecs[3] = mk(1, 9,  18'h00022, 1, 9,  1, 9,   18'h00011, 1, 1, 18'h00011, 1, 1);
      vecs[4] = mk(0, 0,  18'h0,     1, 9,  1, 5,   18'h00022, 1, 0, 18'h2A5A5, 1, 0);
      vecs[5] = mk(1, 63, 18'h3FFFF, 1, 63, 1, 0,   18'h00000, 1, 1, 18'h00000, 1, 0);
      vecs[6] = mk(0, 0,  18'h0,     1, 63, 1, 63,  18'h3FFFF, 1, 0, 18'h3FFFF, 1, 0);
      vecs[7] = mk(1, 0,  18'h00001, 0, 0,  1, 0,   18'h3FFFF, 0, 0, 18'h00000, 1, 1);
      vecs[8] = mk(0, 0,  18'h0,     0, 0,  1, 0,   18'h3FFFF, 0, 0, 18'h00001, 1, 0);
      vecs[9] = mk(0, 0,  18'h0,     0, 0,  0, 0,   18'h3FFFF, 0, 0, 18'h00001, 0, 0);

      rst = 1'b1;
      init_req = 0; wen = 0; aren = 0; bren = 0; waddr = 0; araddr = 0; braddr = 0; wdata = 0;
      k_init_req = 0; k_wen = 0; k_aren = 0; k_bren = 0; k_waddr = 0; k_araddr = 0; k_braddr = 0; k_wdata = 0;

      // ---- reset values ----
      #1;
      check("rst_ardata",  a1_ardata, 0);
      check("rst_arvalid", a1_arvalid, 0);
      check("rst_brvalid", a1_brvalid, 0);
      check("rst_acol",    a1_acol, 0);
      check("rst_err",     a1_err, 0);
      check("rst_busy",    a1_busy, 1);
      check("rst_busy_k",  k_busy, 1);
      repeat (3) step();
      check("rst_hold_arvalid2", a2_arvalid, 0);
      rst = 1'b0;

      // ---- initial clear lasts exactly 64 cycles ----
      busy_samples = a1_busy ? 1 : 0;
      guard = 0;
      while (a1_busy && guard < 200) begin step_cnt(); guard++; end
      check("init_clear_len", busy_samples, 64);
      check("init_clear_busy2", a2_busy, 0);

      // ---- every address reads back zero ----
      for (int i = 0; i < 64; i++) begin
         aren = 1; araddr = 6'(i);
         step();
         check($sformatf("clr_rd%0d", i), {a1_arvalid, a1_ardata}, {1'b1, 18'h0});
      end
      aren = 0;

      // ---- table of ready-state vectors; u2 lags u1 by one cycle ----
      prev = mk(0, 0, 0, 0, 0, 0, 0, 18'h0, 1, 0, 18'h0, 0, 0);
      for (int i = 0; i < 10; i++) begin
         wen = vecs[i].wen; waddr = vecs[i].waddr; wdata = vecs[i].wdata;
         aren = vecs[i].aren; araddr = vecs[i].araddr;
         bren = vecs[i].bren; braddr = vecs[i].braddr;
         step();
         check($sformatf("v%0d_p1_a", i), {a1_acol, a1_arvalid, a1_ardata}, {vecs[i].eac, vecs[i].eav, vecs[i].ea});
         check($sformatf("v%0d_p1_b", i), {a1_bcol, a1_brvalid, a1_brdata}, {vecs[i].ebc, vecs[i].ebv, vecs[i].eb});
         check($sformatf("v%0d_p2_a", i), {a2_acol, a2_arvalid, a2_ardata}, {prev.eac, prev.eav, prev.ea});
         check($sformatf("v%0d_p2_b", i), {a2_bcol, a2_brvalid, a2_brdata}, {prev.ebc, prev.ebv, prev.eb});
         prev = vecs[i];
      end
      wen = 0; aren = 0; bren = 0;

      // ---- init_req clear with a dropped write ----
      wen = 1; waddr = 3; wdata = 18'h00155; step();
      waddr = 7; wdata = 18'h2AAAA; step();
      wen = 0; aren = 1; araddr = 3; step();
      check("pre_clr_rd3", a1_ardata, 18'h00155);
      aren = 0; init_req = 1; step();
      init_req = 0;
      check("req_busy", a1_busy, 1);
      busy_samples = a1_busy ? 1 : 0;
      repeat (9) step_cnt();
      wen = 1; waddr = 3; wdata = 18'h3FFFF; step_cnt();
      check("drop_wr_err", a1_err, 1);
      wen = 0; aren = 1; araddr = 7; init_req = 1; step_cnt();
      check("drop_rd_valid", a1_arvalid, 0);
      check("drop_rd_err", a1_err, 1);
      check("drop_rd_err_p2", a2_err, 1);
      aren = 0; init_req = 0; step_cnt();
      check("err_pulse_end", a1_err, 0);
      guard = 0;
      while (a1_busy && guard < 200) begin step_cnt(); guard++; end
      check("req_clear_len", busy_samples, 64);
      aren = 1; araddr = 3; bren = 1; braddr = 7; step();
      check("post_clr_a3", {a1_arvalid, a1_ardata}, {1'b1, 18'h0});
      check("post_clr_b7", {a1_brvalid, a1_brdata}, {1'b1, 18'h0});
      araddr = 5; braddr = 63; step();
      check("post_clr_a5", {a1_arvalid, a1_ardata}, {1'b1, 18'h0});
      check("post_clr_b63", {a1_brvalid, a1_brdata}, {1'b1, 18'h0});
      aren = 0; bren = 0;

      // ---- reset in the middle of a clear ----
      wen = 1; waddr = 4; wdata = 18'h12345; step();
      wen = 0; aren = 1; araddr = 4; step();
      check("pre_rst_rd4", {a1_arvalid, a1_ardata}, {1'b1, 18'h12345});
      aren = 0; init_req = 1; step();
      init_req = 0;
      repeat (20) step();
      check("clr_hold_data", {a1_arvalid, a1_ardata}, {1'b0, 18'h12345});
      rst = 1; #1;
      check("mid_rst_a1", {a1_arvalid, a1_ardata}, {1'b0, 18'h0});
      check("mid_rst_a2", {a2_arvalid, a2_ardata}, {1'b0, 18'h0});
      step(); step();
      rst = 0;
      k_aren = 1; #1;
      check("k_rd_drop_err_comb", k_err, 1);
      check("k_rd_drop_valid", k_arvalid, 0);
      k_aren = 0; #1;
      busy_samples = a1_busy ? 1 : 0;
      guard = 0;
      while (a1_busy && guard < 200) begin step_cnt(); guard++; end
      check("restart_clear_len", busy_samples, 64);

      // ---- RAM1Kx1, combinational read ----
      guard = 0;
      while (k_busy && guard < 1100) begin step(); guard++; end
      check("k_clear_done", k_busy, 0);
      k_wen = 1; k_waddr = 10'd1023; k_wdata = 1'b1;
      k_aren = 1; k_araddr = 10'd1023; #1;
      check("k_col_a", {k_acol, k_arvalid, k_ardata}, {1'b1, 1'b1, 1'b0});
      step();
      k_wen = 0; k_araddr = 10'd1023; k_bren = 1; k_braddr = 10'd0; #1;
      check("k_a1023", {k_acol, k_arvalid, k_ardata}, {1'b0, 1'b1, 1'b1});
      check("k_b0",    {k_bcol, k_brvalid, k_brdata}, {1'b0, 1'b1, 1'b0});
      step();
      k_araddr = 10'd0; k_braddr = 10'd1023; #1;
      check("k_a0",    {k_arvalid, k_ardata}, {1'b1, 1'b0});
      check("k_b1023", {k_brvalid, k_brdata}, {1'b1, 1'b1});
      step();
      k_aren = 0; k_bren = 0; #1;
      check("k_b_hold", {k_brvalid, k_brdata}, {1'b0, 1'b1});

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
